// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, instruction fetch handshake and FETCH/EXEC/HALT sequencer
module pc_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000000,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_o,
  output logic             instr_valid,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_plus4_o,
  input  logic [1:0]       PCSrc2,
  input  logic [XLEN-1:0]  ImmExt,
  input  logic [XLEN-1:0]  ALUResult,
  input  logic             stall,
  output logic             misalign_trap,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [31:0]      NOP      = 32'h00000013;
  localparam logic [XLEN-1:0]  FOUR     = XLEN'(4);
  localparam logic [XLEN-1:0]  LSB_MASK = ~XLEN'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q;
  logic [31:0]      instr_q;
  logic [CNT_W-1:0] instret_q;
  logic             trap_q;

  logic [XLEN-1:0]  next_pc;
  logic             load_instr;
  logic             commit;
  logic             set_trap;

  // Next-PC mux; jalr clears bit 0 so an odd rs1+imm is still a legal target
  always_comb begin
    next_pc = pc_q + FOUR;
    case (PCSrc2)
      2'b00:   next_pc = pc_q + FOUR;
      2'b01:   next_pc = pc_q + ImmExt;
      default: next_pc = ALUResult & LSB_MASK;
    endcase
  end

  // Sequencer next-state and register-update strobes
  always_comb begin
    state_d    = state_q;
    load_instr = 1'b0;
    commit     = 1'b0;
    set_trap   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_rvalid) begin
          load_instr = 1'b1;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (next_pc[1:0] == 2'b00) begin
            commit  = 1'b1;
            state_d = S_FETCH;
          end else begin
            set_trap = 1'b1;
            state_d  = S_HALT;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State, PC, instruction register, retire counter and sticky trap
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      instret_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_instr) instr_q <= imem_rdata;
      if (commit) begin
        pc_q      <= next_pc;
        instret_q <= instret_q + CNT_ONE;
      end
      if (set_trap) trap_q <= 1'b1;
    end
  end

  assign imem_req      = (state_q == S_FETCH);
  assign instr_valid   = (state_q == S_EXEC);
  assign halted        = (state_q == S_HALT);
  assign imem_addr     = pc_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + FOUR;
  assign instr_o       = instr_q;
  assign instret       = instret_q;
  assign misalign_trap = trap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed bench with behavioural fetch-stage model
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_o;
  logic        instr_valid;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [1:0]  PCSrc2;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic        stall;
  logic        misalign_trap;
  logic        halted;
  logic [31:0] instret;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_o(instr_o), .instr_valid(instr_valid),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .PCSrc2(PCSrc2), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .stall(stall), .misalign_trap(misalign_trap),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 waiting for instruction, 1 executing, 2 stopped
  int          m_phase = 0;
  logic [31:0] m_pc = 0, m_ir = 32'h13, m_cnt = 0, m_tgt;
  bit          m_trap = 0;

  // Advance the model on each rising edge from the inputs the DUT sees
  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_pc = 0; m_ir = 32'h13; m_cnt = 0; m_trap = 0;
    end else if (m_phase == 0) begin
      if (imem_rvalid) begin m_ir = imem_rdata; m_phase = 1; end
    end else if (m_phase == 1 && !stall) begin
      if (PCSrc2 == 2'b00)      m_tgt = m_pc + 4;
      else if (PCSrc2 == 2'b01) m_tgt = m_pc + ImmExt;
      else                      m_tgt = ALUResult - (ALUResult % 2);
      if (m_tgt % 4 == 0) begin m_pc = m_tgt; m_cnt = m_cnt + 1; m_phase = 0; end
      else begin m_trap = 1; m_phase = 2; end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Compare every DUT output against the model away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      check("imem_req",      32'(imem_req),      32'(m_phase == 0));
      check("instr_valid",   32'(instr_valid),   32'(m_phase == 1));
      check("halted",        32'(halted),        32'(m_phase == 2));
      check("pc_o",          pc_o,               m_pc);
      check("imem_addr",     imem_addr,          m_pc);
      check("pc_plus4_o",    pc_plus4_o,         m_pc + 4);
      check("instr_o",       instr_o,            m_ir);
      check("instret",       instret,            m_cnt);
      check("misalign_trap", 32'(misalign_trap), 32'(m_trap));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One instruction from FETCH with zero-wait memory: fetch cycle then exec cycle
  task automatic instr(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    imem_rvalid = 1'b1; PCSrc2 = src; ImmExt = imm; ALUResult = alu; stall = 1'b0;
    step(2);
  endtask

  initial begin
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h13;
    PCSrc2 = 2'b00; ImmExt = 0; ALUResult = 0; stall = 1'b0;
    step(2);
    rst = 1'b0;
    check_en = 1'b1;
    check("reset_pc", pc_o, 32'h0);
    check("reset_instr", instr_o, 32'h00000013);
    check("reset_req", 32'(imem_req), 32'd1);

    // Sequential fetch, zero-wait memory
    imem_rvalid = 1'b1; imem_rdata = 32'h13; PCSrc2 = 2'b00;
    step(2); check("seq_pc4", pc_o, 32'h4);
    step(2); check("seq_pc8", pc_o, 32'h8);
    step(2); check("seq_instret3", instret, 32'd3);
    check("seq_pc12", pc_o, 32'hC);

    // Branch offsets relative to 0x100
    instr(2'b10, 0, 32'h100);         check("jalr_0x100", pc_o, 32'h100);
    instr(2'b01, 32'hFFFFFFF0, 0);    check("br_neg", pc_o, 32'hF0);
    instr(2'b10, 0, 32'h100);
    instr(2'b01, 32'h20, 0);          check("br_pos", pc_o, 32'h120);

    // jalr clears bit 0
    instr(2'b11, 0, 32'h205);         check("jalr_odd", pc_o, 32'h204);
    check("jalr_odd_trap", 32'(misalign_trap), 32'd0);

    // Wrap at top of address space
    instr(2'b10, 0, 32'hFFFFFFFC);    check("wrap_plus4", pc_plus4_o, 32'h0);
    instr(2'b00, 0, 0);               check("wrap_pc", pc_o, 32'h0);
    check("wrap_instret", instret, 32'd10);

    // Stall holds EXEC
    imem_rvalid = 1'b1; PCSrc2 = 2'b00; step(1);
    stall = 1'b1; step(3);
    check("stall_pc", pc_o, 32'h0);
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_instret", instret, 32'd10);
    stall = 1'b0; step(1);
    check("stall_release_pc", pc_o, 32'h4);
    check("stall_release_instret", instret, 32'd11);

    // Delayed response, then stray rvalid in EXEC
    imem_rvalid = 1'b0; imem_rdata = 32'hDEADBEEF; step(4);
    check("wait_req", 32'(imem_req), 32'd1);
    check("wait_instr", instr_o, 32'h00000013);
    imem_rvalid = 1'b1; imem_rdata = 32'h00A00093; step(1);
    check("rvalid_instr", instr_o, 32'h00A00093);
    imem_rdata = 32'h12345678; stall = 1'b1; step(2);
    check("stray_instr", instr_o, 32'h00A00093);
    stall = 1'b0; imem_rvalid = 1'b0; step(1);
    check("after_stray_pc", pc_o, 32'h8);

    // Misaligned jalr target traps and halts
    imem_rdata = 32'h13;
    instr(2'b11, 0, 32'h206);
    check("trap_set", 32'(misalign_trap), 32'd1);
    check("trap_halted", 32'(halted), 32'd1);
    check("trap_pc", pc_o, 32'h8);
    step(10);
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_instret", instret, 32'd12);

    // Reset from HALT
    rst = 1'b1; step(1); rst = 1'b0;
    check("rst_halt_pc", pc_o, 32'h0);
    check("rst_halt_trap", 32'(misalign_trap), 32'd0);
    check("rst_halt_instret", instret, 32'd0);
    check("rst_halt_req", 32'(imem_req), 32'd1);

    // Reset mid-FETCH
    imem_rdata = 32'h00A00093;
    instr(2'b00, 0, 0);
    imem_rvalid = 1'b0; step(2);
    check("midfetch_pre_pc", pc_o, 32'h4);
    rst = 1'b1; step(1); rst = 1'b0;
    check("rst_fetch_pc", pc_o, 32'h0);
    check("rst_fetch_instr", instr_o, 32'h00000013);
    check("rst_fetch_instret", instret, 32'd0);
    step(2);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
